// File: rtl/alu_pkg.sv
// Shared types for alu_multicycle: op codes, FSM states and the iterative-op test.
// divu/remu count as iterative only when ALU_DIV_EN is defined.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_SLL   = 4'h5,
    OP_SRL   = 4'h6,
    OP_SRA   = 4'h7,
    OP_SLT   = 4'h8,
    OP_SLTU  = 4'h9,
    OP_MUL   = 4'hA,
    OP_MULHU = 4'hB,
    OP_DIVU  = 4'hC,
    OP_REMU  = 4'hD,
    OP_RSV0  = 4'hE,
    OP_RSV1  = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  function automatic logic is_iterative(input alu_op_e op);
    case (op)
      OP_MUL, OP_MULHU: return 1'b1;
`ifdef ALU_DIV_EN
      OP_DIVU, OP_REMU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_if.sv
// Handshake bundle between the issuing stage (master) and alu_multicycle (slave).
interface alu_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic [3:0]       alu_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, operand1, operand2, alu_op, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, operand1, operand2, alu_op, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_iter_unit.sv
// Iterative datapath: shift-add multiplier (LSB first) and, with ALU_DIV_EN, a restoring
// divider (MSB first). done is high during the final step; res is that step's outcome.
module alu_iter_unit
  import alu_pkg::*;
#(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt;
  logic             run;
  alu_op_e          op_q;
  logic [WIDTH-1:0] mcand, hi, lo;
  logic [WIDTH:0]   psum;

  assign psum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
  assign done = run & (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      run   <= 1'b0;
      op_q  <= OP_ADD;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (start) begin
      cnt   <= '0;
      run   <= 1'b1;
      op_q  <= op;
      mcand <= a;
      hi    <= '0;
      lo    <= b;
    end else if (run) begin
      hi  <= psum[WIDTH:1];
      lo  <= {psum[0], lo[WIDTH-1:1]};
      cnt <= cnt + CW'(1);
      if (done) run <= 1'b0;
    end
  end

`ifdef ALU_DIV_EN
  logic [WIDTH-1:0] dvsr, q, r, dif, q_nxt, r_nxt;
  logic [WIDTH:0]   shl;
  logic             ge;

  // A zero divisor makes ge true every step, giving all-ones and the dividend naturally.
  assign shl   = {r, q[WIDTH-1]};
  assign ge    = shl >= {1'b0, dvsr};
  assign dif   = shl[WIDTH-1:0] - dvsr;
  assign q_nxt = {q[WIDTH-2:0], ge};
  assign r_nxt = ge ? dif : shl[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvsr <= '0;
      q    <= '0;
      r    <= '0;
    end else if (start) begin
      dvsr <= b;
      q    <= a;
      r    <= '0;
    end else if (run) begin
      q <= q_nxt;
      r <= r_nxt;
    end
  end
`endif

  always_comb begin
    res = {psum[0], lo[WIDTH-1:1]};
    case (op_q)
      OP_MULHU: res = psum[WIDTH:1];
`ifdef ALU_DIV_EN
      OP_DIVU:  res = q_nxt;
      OP_REMU:  res = r_nxt;
`endif
      default:  res = {psum[0], lo[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// WIDTH-bit handshaked ALU; single-cycle ops here, mul/mulhu (and divu/remu when
// ALU_DIV_EN is defined) in alu_iter_unit. All outputs except in_ready are registered.
module alu_multicycle
  import alu_pkg::*;
#(parameter int WIDTH = 32) (
  input logic  clk,
  input logic  rst_n,
  alu_if.slave bus
);
  // state | meaning
  // IDLE  | nothing held, ready to accept
  // BUSY  | iterative op running in alu_iter_unit
  // DONE  | result held until out_ready
  localparam int CW = $clog2(WIDTH);

  alu_state_e       state_q;
  logic             out_valid_q, zero_q, busy_q;
  logic [WIDTH-1:0] result_q, alu_res, iter_res, a, b;
  logic [CW-1:0]    sh;
  logic             in_ready, accept, iter_go, iter_done;
  alu_op_e          op;

  assign a        = bus.operand1;
  assign b        = bus.operand2;
  assign sh       = b[CW-1:0];
  assign op       = alu_op_e'(bus.alu_op);
  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
  assign accept   = bus.in_valid & in_ready;
  assign iter_go  = accept & is_iterative(op);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.busy      = busy_q;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << sh;
      OP_SRL:  alu_res = a >> sh;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> sh);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      default: alu_res = '0;
    endcase
  end

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (iter_go),
    .op    (op),
    .a     (a),
    .b     (b),
    .done  (iter_done),
    .res   (iter_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept && iter_go) begin
            state_q     <= BUSY;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b0;
          end else if (accept) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= alu_res;
            zero_q      <= (alu_res == '0);
          end else if (in_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        BUSY: begin
          if (iter_done) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            result_q    <= iter_res;
            zero_q      <= (iter_res == '0);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32): directed table, handshake corner
// sequences and randomized ops against an arithmetic reference model.
module tb_alu_multicycle;
  localparam int W = 32;
`ifdef ALU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif
  localparam int DLAT = DIV_ON ? W + 1 : 1;

  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, AND_ = 4'h2, OR_ = 4'h3, XOR_ = 4'h4;
  localparam logic [3:0] SLL = 4'h5, SRL = 4'h6, SRA = 4'h7, SLT = 4'h8, SLTU = 4'h9;
  localparam logic [3:0] MUL = 4'hA, MULHU = 4'hB, DIVU = 4'hC, REMU = 4'hD;

  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  alu_if #(.WIDTH(W)) bus();
  alu_multicycle #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    int sh;
    sh = int'(b[4:0]);
    p  = 64'(a) * 64'(b);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return a << sh;
      4'h6: return a >> sh;
      4'h7: return a[31] ? ~((~a) >> sh) : (a >> sh);
      4'h8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'h9: return (a < b) ? 32'd1 : 32'd0;
      4'hA: return p[31:0];
      4'hB: return p[63:32];
      4'hC: return !DIV_ON ? 32'd0 : (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'hD: return !DIV_ON ? 32'd0 : (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op);
    if (op == MUL || op == MULHU) return W + 1;
    if (op == DIVU || op == REMU) return DLAT;
    return 1;
  endfunction

  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat, bcnt, guard;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.alu_op = op; bus.operand1 = a; bus.operand2 = b;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({nm, " in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.alu_op = 4'($urandom); bus.operand1 = $urandom; bus.operand2 = $urandom;
    lat = 1; bcnt = 0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, " result"}, bus.result, exp);
    chk({nm, " zero"}, 32'(bus.zero), 32'(exp == 0));
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " busy_cycles"}, 32'(bcnt), 32'(exp_lat - 1));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.alu_op = 4'h0; bus.operand1 = '0; bus.operand2 = '0;

    vecs.push_back('{"add", ADD, 32'd5, 32'd7, 32'd12, 1});
    vecs.push_back('{"sub", SUB, 32'd9, 32'd9, 32'd0, 1});
    vecs.push_back('{"add_wrap", ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1});
    vecs.push_back('{"and", AND_, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1});
    vecs.push_back('{"or", OR_, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 1});
    vecs.push_back('{"xor", XOR_, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 1});
    vecs.push_back('{"sll_upper_ignored", SLL, 32'd1, 32'h0000_0021, 32'd2, 1});
    vecs.push_back('{"srl31", SRL, 32'h8000_0000, 32'd31, 32'd1, 1});
    vecs.push_back('{"sra4", SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1});
    vecs.push_back('{"slt_neg", SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1});
    vecs.push_back('{"slt_pos", SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1});
    vecs.push_back('{"sltu_big", SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1});
    vecs.push_back('{"mul", MUL, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 33});
    vecs.push_back('{"mulhu2", MULHU, 32'hFFFF_FFFF, 32'd2, 32'd1, 33});
    vecs.push_back('{"mul_max", MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33});
    vecs.push_back('{"mulhu_max", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    vecs.push_back('{"divu", DIVU, 32'd100, 32'd7, DIV_ON ? 32'd14 : 32'd0, DLAT});
    vecs.push_back('{"remu", REMU, 32'd100, 32'd7, DIV_ON ? 32'd2 : 32'd0, DLAT});
    vecs.push_back('{"divu_by0", DIVU, 32'd5, 32'd0, DIV_ON ? 32'hFFFF_FFFF : 32'd0, DLAT});
    vecs.push_back('{"remu_by0", REMU, 32'd9, 32'd0, DIV_ON ? 32'd9 : 32'd0, DLAT});
    vecs.push_back('{"rsv_e", 4'hE, 32'd3, 32'd4, 32'd0, 1});
    vecs.push_back('{"rsv_f", 4'hF, 32'd3, 32'd4, 32'd0, 1});

    // reset values while held in reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst result", bus.result, 32'd0);
    chk("rst zero", 32'(bus.zero), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                             vecs[i].lat);

    // back-to-back single-cycle ops with out_ready held high
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.alu_op = SRA; bus.operand1 = 32'h8000_0000; bus.operand2 = 32'd4;
    chk("b2b in_ready0", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    chk("b2b sra valid", 32'(bus.out_valid), 32'd1);
    chk("b2b sra result", bus.result, 32'hF800_0000);
    chk("b2b in_ready1", 32'(bus.in_ready), 32'd1);
    bus.alu_op = SLTU; bus.operand1 = 32'd1; bus.operand2 = 32'd2;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("b2b sltu valid", 32'(bus.out_valid), 32'd1);
    chk("b2b sltu result", bus.result, 32'd1);

    // stall the consumer after a mul, then accept an add in the release cycle
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    run_op("stall_mul", MUL, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 33);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall result", bus.result, 32'hFFFF_FFFF);
      chk("stall out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    bus.alu_op = ADD; bus.operand1 = 32'd3; bus.operand2 = 32'd4;
    #1;
    chk("release in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("release add valid", 32'(bus.out_valid), 32'd1);
    chk("release add result", bus.result, 32'd7);

    // reset 10 cycles into a mul aborts it
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.alu_op = MUL; bus.operand1 = 32'd3; bus.operand2 = 32'd5;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort result", bus.result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("post_reset_add", ADD, 32'd2, 32'd2, 32'd4, 1);

    // randomized ops against the reference model
    for (int n = 0; n < 120; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      run_op("rand", rop, ra, rb, model(rop, ra, rb), model_lat(rop));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
